// File: rtl/stream_reduce_pkg.sv
// Shared types and constants for the frame reduction block.
package stream_reduce_pkg;

  // ACCUM collects beats of a frame, HOLD presents the finished result.
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Identity values of the three folds, used at reset and between frames.
  localparam logic ACC_AND_INIT = 1'b1;
  localparam logic ACC_OR_INIT  = 1'b0;
  localparam logic ACC_XOR_INIT = 1'b0;

endpackage : stream_reduce_pkg

// File: rtl/word_reduce.sv
// Combinational AND/OR/XOR reduction of a single beat.
module word_reduce #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  output logic             r_and,
  output logic             r_or,
  output logic             r_xor
);

  assign r_and = &data;
  assign r_or  = |data;
  assign r_xor = ^data;

endmodule : word_reduce

// File: rtl/stream_reduce.sv
// Folds every bit of every beat of a valid/ready frame into frame-level
// AND, OR and XOR results, with a saturating beat count and overflow flag.
module stream_reduce
  import stream_reduce_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int MAX_BEATS = 16,
  localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_and,
  output logic             out_or,
  output logic             out_xor,
  output logic [CNT_W-1:0] out_beats,
  output logic             out_overflow
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

  state_t           state_q, state_d;
  logic             accAnd_q, accAnd_d;
  logic             accOr_q, accOr_d;
  logic             accXor_q, accXor_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             outAnd_q, outAnd_d;
  logic             outOr_q, outOr_d;
  logic             outXor_q, outXor_d;
  logic [CNT_W-1:0] outBeats_q, outBeats_d;
  logic             outOvf_q, outOvf_d;

  logic             beatAnd, beatOr, beatXor;
  logic             accept, atLimit, frameDone;
  logic             foldAnd, foldOr, foldXor, foldOvf;
  logic [CNT_W-1:0] cntSat;

  word_reduce #(
    .WIDTH(WIDTH)
  ) u_word_reduce (
    .data (in_data),
    .r_and(beatAnd),
    .r_or (beatOr),
    .r_xor(beatXor)
  );

  assign accept    = in_valid && in_ready;
  assign frameDone = accept && in_last && !clr;
  assign atLimit   = (cnt_q == MAX_CNT);
  assign cntSat    = atLimit ? cnt_q : cnt_q + CNT_W'(1);
  assign foldAnd   = accAnd_q & beatAnd;
  assign foldOr    = accOr_q | beatOr;
  assign foldXor   = accXor_q ^ beatXor;
  assign foldOvf   = ovf_q | atLimit;

  // State register; reset drops any partial frame or held result at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  // Next state: a last beat moves to HOLD, the output handshake returns to ACCUM, clr wins over both.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ACCUM;
    end else begin
      case (state_q)
        ACCUM:   if (accept && in_last) state_d = HOLD;
        HOLD:    if (out_ready)         state_d = ACCUM;
        default: state_d = ACCUM;
      endcase
    end
  end

  // Handshake outputs depend on state only, so there is no ready-to-ready path.
  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == HOLD);
  end

  // Accumulator next values: restart on clr or frame end, otherwise fold the accepted beat in.
  always_comb begin
    accAnd_d = accAnd_q;
    accOr_d  = accOr_q;
    accXor_d = accXor_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (clr || (accept && in_last)) begin
      accAnd_d = ACC_AND_INIT;
      accOr_d  = ACC_OR_INIT;
      accXor_d = ACC_XOR_INIT;
      cnt_d    = '0;
      ovf_d    = 1'b0;
    end else if (accept) begin
      accAnd_d = foldAnd;
      accOr_d  = foldOr;
      accXor_d = foldXor;
      cnt_d    = cntSat;
      ovf_d    = foldOvf;
    end
  end

  // Result next values: capture the folds including the last beat; otherwise keep the old result.
  always_comb begin
    outAnd_d   = outAnd_q;
    outOr_d    = outOr_q;
    outXor_d   = outXor_q;
    outBeats_d = outBeats_q;
    outOvf_d   = outOvf_q;
    if (frameDone) begin
      outAnd_d   = foldAnd;
      outOr_d    = foldOr;
      outXor_d   = foldXor;
      outBeats_d = cntSat;
      outOvf_d   = foldOvf;
    end
  end

  // Accumulator and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accAnd_q   <= ACC_AND_INIT;
      accOr_q    <= ACC_OR_INIT;
      accXor_q   <= ACC_XOR_INIT;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      outAnd_q   <= 1'b0;
      outOr_q    <= 1'b0;
      outXor_q   <= 1'b0;
      outBeats_q <= '0;
      outOvf_q   <= 1'b0;
    end else begin
      accAnd_q   <= accAnd_d;
      accOr_q    <= accOr_d;
      accXor_q   <= accXor_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      outAnd_q   <= outAnd_d;
      outOr_q    <= outOr_d;
      outXor_q   <= outXor_d;
      outBeats_q <= outBeats_d;
      outOvf_q   <= outOvf_d;
    end
  end

  assign out_and      = outAnd_q;
  assign out_or       = outOr_q;
  assign out_xor      = outXor_q;
  assign out_beats    = outBeats_q;
  assign out_overflow = outOvf_q;

endmodule : stream_reduce

// File: doc/stream_reduce.md
Name: stream_reduce

Overview:
Sequential, parametrised successor to the team's combinational 4-bit AND/OR/XOR reduction block. Accepts a stream of WIDTH-bit beats over a valid/ready handshake and folds every bit of every beat in a frame into frame-level AND, OR and XOR (parity) results. Frames are delimited by in_last. Sits between a data source and any consumer that needs frame parity or all-zero/all-one checks, such as integrity checkers and status logic.

Parameters:
WIDTH, 8, bits per input beat (>=1)
MAX_BEATS, 16, beat-count saturation limit per frame (>=1)
CNT_W, $clog2(MAX_BEATS+1), width of the beat counter (derived; not to be overridden)

Ports:
clk  input  1  clock, all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous abort: discards the partial frame and any held result
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat
in_data  input  WIDTH  beat payload
in_last  input  1  final beat of the frame
out_valid  output  1  frame result valid
out_ready  input  1  consumer accepts the result
out_and  output  1  AND of all bits of all beats in the frame
out_or  output  1  OR of all bits of all beats in the frame
out_xor  output  1  XOR of all bits of all beats in the frame
out_beats  output  CNT_W  number of beats in the frame, saturating at MAX_BEATS
out_overflow  output  1  frame had more than MAX_BEATS beats

Behaviour:
- Reset (rst_n=0, asynchronous): state ACCUM; accumulators acc_and=1, acc_or=0, acc_xor=0, cnt=0, ovf=0; out_valid=0; out_and/out_or/out_xor=0; out_beats=0; out_overflow=0.
- States: ACCUM (collecting beats) and HOLD (result presented).
- in_ready = (state==ACCUM). It is combinational from state only, never from out_ready; there is no same-cycle bypass.
- Beat accepted when in_valid && in_ready:
  - acc_and &= &in_data; acc_or |= |in_data; acc_xor ^= ^in_data.
  - cnt increments, saturating at MAX_BEATS.
  - If cnt==MAX_BEATS before the increment, ovf=1. The beat is still reduced.
- Accepted beat with in_last=1:
  - The output registers load the accumulators with this beat already folded in.
  - out_beats = saturated cnt+1; out_overflow = ovf (including an overflow caused by this beat).
  - out_valid=1 on the next edge (latency 1 cycle from the last-beat acceptance edge). State goes to HOLD.
  - Accumulators reinitialise to their reset values on the same edge.
- HOLD: the outputs are stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_valid=0 and state ACCUM at the next edge.
  - in_ready rises one cycle after the handshake.
  - out_and/out_or/out_xor/out_beats/out_overflow keep their last values after out_valid falls.
- Single-beat frame (in_last on the first beat): legal. The result equals the plain reductions of that beat, and out_beats=1.
- Empty frames cannot occur, because in_last must accompany a beat.
- clr=1: at the next edge, accumulators return to reset values, out_valid=0, state ACCUM. The output data fields are left unchanged. clr has priority over any same-cycle beat acceptance or output handshake; that beat is dropped.
- Reset mid-frame or mid-HOLD: all state is discarded immediately, with no partial result emitted.
- in_data and in_last are ignored when the beat is not accepted. Source protocol: in_valid, once raised, stays high until accepted.

Decomposition:
- Package stream_reduce_pkg:
  - state enum {ACCUM, HOLD};
  - accumulator reset constants (ACC_AND_INIT=1, ACC_OR_INIT=0, ACC_XOR_INIT=0).
- Sub-module word_reduce: purely combinational, parameter WIDTH, input data, outputs r_and/r_or/r_xor. It is instantiated once and gives the per-beat reductions.
- FSM, counter and output registers live in stream_reduce.

Test Plan:
Run all scenarios with WIDTH=8, MAX_BEATS=4.
1. Single beat 8'hFF with in_last, out_ready=1 -> one cycle later out_valid=1, and=1, or=1, xor=0, beats=1, overflow=0; in_ready returns 2 cycles after acceptance.
2. Frame 8'hFF, 8'h01(last) -> and=0, or=1, xor=1, beats=2. Then frame 8'h00 x3 (last on 3rd) -> and=0, or=0, xor=0, beats=3; confirms accumulators reinitialise between frames.
3. Backpressure: complete frame 8'hA5(last), hold out_ready=0 for 5 cycles with in_valid=1 -> out_valid and outputs stable (and=0, or=1, xor=0), in_ready=0, no beats accepted. Raise out_ready -> out_valid drops next edge.
4. Overflow: 6 beats of 8'h07 (last on 6th) -> beats=4, overflow=1, and=0, or=1, xor=0. The next frame 8'hFF(last) reports overflow=0, beats=1.
5. Abort: 2 beats of 8'h01, assert clr for 1 cycle, then 8'hFF(last) -> and=1, or=1, xor=0, beats=1. clr asserted with a same-cycle last beat -> no out_valid.
6. Async reset: drop rst_n mid-frame and again during HOLD without a clock edge -> out_valid=0, all outputs 0 immediately. After release, frame 8'h80(last) -> and=0, or=1, xor=1, beats=1.
